switch_event_ctrl: RTL and testbench

SWITCH_EVENT_CTRL -- requirements
Module: switch_event_ctrl

---
 rtl/switch_event_pkg.sv | 28 ++
 rtl/switch_event_ctrl_if.sv | 19 +
 rtl/switch_debounce_bit.sv | 80 ++++++++
 rtl/switch_event_ctrl.sv | 152 +++++++++++++++
 tb/tb_switch_event_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/switch_event_pkg.sv
// Shared definitions for the switch event controller.
// Contents:
//   ADDR_*      register word addresses on the Avalon-MM slave
//   edge_sel_e  edge-select encoding held in the cfg register
//   CFG_RESET   cfg value after reset (both edges)
//   state_e     controller state (INIT until the first load, then RUN)
package switch_event_pkg;

   localparam logic [1:0] ADDR_STABLE = 2'd0;
   localparam logic [1:0] ADDR_MASK   = 2'd1;
   localparam logic [1:0] ADDR_EDGE   = 2'd2;
   localparam logic [1:0] ADDR_CFG    = 2'd3;

   typedef enum logic [1:0] {
      EDGE_NONE = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_sel_e;

   localparam edge_sel_e CFG_RESET = EDGE_BOTH;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/switch_event_ctrl_if.sv
// Avalon-MM slave bus of the switch event controller.
// Signals:
//   address    [1:0]  word address
//   read, write       strobes
//   writedata  [31:0] write data
//   readdata   [31:0] registered read data, driven by the slave
// Modports: master (bus driver), slave (switch_event_ctrl).
interface switch_event_ctrl_if;

   logic [1:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, read, write, writedata, input readdata);
   modport slave  (input address, read, write, writedata, output readdata);

endinterface

// File: rtl/switch_debounce_bit.sv
// One switch bit: debounce counter plus the accepted (stable) level.
// Build option: SWITCH_EVENT_CTRL_DEBOUNCE_EN compiles the counter; without it
// the stable flop simply follows the synchronized input every cycle.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   tick         debounce sample strobe           (debounce build only)
//   load         initial load of the stable level (debounce build only)
//   run          controller is in RUN             (debounce build only)
//   sync_in      synchronized switch level
//   stable_q     accepted level (registered)
//   stable_d     next accepted level, used by the parent for edge detection
module switch_debounce_bit
`ifdef SWITCH_EVENT_CTRL_DEBOUNCE_EN
   #(parameter int STABLE_CNT = 4)
`endif
   (
   input  logic clk,
   input  logic reset,
`ifdef SWITCH_EVENT_CTRL_DEBOUNCE_EN
   input  logic tick,
   input  logic load,
   input  logic run,
`endif
   input  logic sync_in,
   output logic stable_q,
   output logic stable_d
);

`ifdef SWITCH_EVENT_CTRL_DEBOUNCE_EN
   logic [3:0] cnt_q, cnt_d;

   // NOTE: every always_comb output gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (load) begin
         stable_d = sync_in;
         cnt_d    = '0;
      end else if (run && tick) begin
         if (sync_in != stable_q) begin
            // Accept the new level on the STABLE_CNT-th differing tick.
            if (cnt_q == 4'(STABLE_CNT - 1)) begin
               stable_d = sync_in;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end else begin
            cnt_d = '0;
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the values from before the edge, independent of block order.
   always_ff @(posedge clk) begin
      if (reset) begin
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end
`else
   assign stable_d = sync_in;

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the values from before the edge, independent of block order.
   always_ff @(posedge clk) begin
      if (reset) begin
         stable_q <= 1'b0;
      end else begin
         stable_q <= stable_d;
      end
   end
`endif

endmodule

// File: rtl/switch_event_ctrl.sv
// Debounced switch input port with edge capture and a level interrupt,
// accessed through an Avalon-MM slave.
// Build option: SWITCH_EVENT_CTRL_DEBOUNCE_EN enables the tick-based debounce
// filter; otherwise the stable level follows the synchronizer and INIT lasts
// a single cycle.
// Ports:
//   clk      system clock (rising edge)
//   reset    synchronous active-high reset
//   bus      Avalon-MM slave (address, read, write, writedata, readdata)
//   in_port  raw asynchronous switch levels [WIDTH-1:0]
//   irq      level interrupt: OR of (edge capture AND mask), registered
// Registers: 0 stable (RO), 1 mask (RW), 2 edge capture (W1C), 3 cfg[1:0] (RW).
module switch_event_ctrl
   import switch_event_pkg::*;
#(
   parameter int WIDTH      = 18,
   parameter int TICK_DIV   = 50000,
   parameter int STABLE_CNT = 4
) (
   input  logic                clk,
   input  logic                reset,
   switch_event_ctrl_if.slave  bus,
   input  logic [WIDTH-1:0]    in_port,
   output logic                irq
);

   logic [WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [WIDTH-1:0] mask_q, mask_d, cap_q, cap_d;
   logic [WIDTH-1:0] rise, fall, edge_vec;
   edge_sel_e        cfg_q, cfg_d;
   logic [31:0]      readdata_q, readdata_d;
   logic             irq_q, irq_d;
   state_e           state_q, state_d;

`ifdef SWITCH_EVENT_CTRL_DEBOUNCE_EN
   localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic          tick, load, run;

   assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));
   assign load = (state_q == ST_INIT) && tick;
   assign run  = (state_q == ST_RUN);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      switch_debounce_bit #(.STABLE_CNT(STABLE_CNT)) u_bit (
         .clk      (clk),
         .reset    (reset),
         .tick     (tick),
         .load     (load),
         .run      (run),
         .sync_in  (sync2_q[i]),
         .stable_q (stable_q[i]),
         .stable_d (stable_d[i])
      );
   end
`else
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      switch_debounce_bit u_bit (
         .clk      (clk),
         .reset    (reset),
         .sync_in  (sync2_q[i]),
         .stable_q (stable_q[i]),
         .stable_d (stable_d[i])
      );
   end
`endif

   always_comb begin
      sync1_d = in_port;
      sync2_d = sync1_q;

      state_d = state_q;
`ifdef SWITCH_EVENT_CTRL_DEBOUNCE_EN
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
      if (load) state_d = ST_RUN;
`else
      if (state_q == ST_INIT) state_d = ST_RUN;
`endif

      // Edges are only meaningful once the stable level has been loaded.
      rise     = stable_d & ~stable_q;
      fall     = ~stable_d & stable_q;
      edge_vec = '0;
      if (state_q == ST_RUN) begin
         case (cfg_q)
            EDGE_RISE: edge_vec = rise;
            EDGE_FALL: edge_vec = fall;
            EDGE_BOTH: edge_vec = rise | fall;
            default:   edge_vec = '0;
         endcase
      end

      mask_d = mask_q;
      cap_d  = cap_q;
      cfg_d  = cfg_q;
      if (bus.write) begin
         case (bus.address)
            ADDR_MASK: mask_d = bus.writedata[WIDTH-1:0];
            ADDR_EDGE: cap_d  = cap_q & ~bus.writedata[WIDTH-1:0];
            ADDR_CFG:  cfg_d  = edge_sel_e'(bus.writedata[1:0]);
            default:   ;
         endcase
      end
      // Applied after the clear so a new edge wins over a same-cycle W1C.
      cap_d = cap_d | edge_vec;

      readdata_d = readdata_q;
      if (bus.read) begin
         case (bus.address)
            ADDR_STABLE: readdata_d = 32'(stable_q);
            ADDR_MASK:   readdata_d = 32'(mask_q);
            ADDR_EDGE:   readdata_d = 32'(cap_q);
            default:     readdata_d = 32'(cfg_q);
         endcase
      end

      irq_d = |(cap_q & mask_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         mask_q     <= '0;
         cap_q      <= '0;
         cfg_q      <= CFG_RESET;
         readdata_q <= '0;
         irq_q      <= 1'b0;
         state_q    <= ST_INIT;
`ifdef SWITCH_EVENT_CTRL_DEBOUNCE_EN
         tick_cnt_q <= '0;
`endif
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         mask_q     <= mask_d;
         cap_q      <= cap_d;
         cfg_q      <= cfg_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
         state_q    <= state_d;
`ifdef SWITCH_EVENT_CTRL_DEBOUNCE_EN
         tick_cnt_q <= tick_cnt_d;
`endif
      end
   end

   assign bus.readdata = readdata_q;
   assign irq          = irq_q;

endmodule

// File: tb/tb_switch_event_ctrl.sv
// Self-checking bench for switch_event_ctrl (TICK_DIV=4, STABLE_CNT=3,
// WIDTH=18). Works with and without SWITCH_EVENT_CTRL_DEBOUNCE_EN.
module tb_switch_event_ctrl;

   localparam int WIDTH      = 18;
   localparam int TICK_DIV   = 4;
   localparam int STABLE_CNT = 3;
   localparam int SETTLE     = 2 + (STABLE_CNT + 1) * TICK_DIV + 6;
`ifdef SWITCH_EVENT_CTRL_DEBOUNCE_EN
   localparam bit DEB = 1'b1;
`else
   localparam bit DEB = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [WIDTH-1:0] in_port = '0;
   logic             irq;

   switch_event_ctrl_if bus ();

   switch_event_ctrl #(
      .WIDTH      (WIDTH),
      .TICK_DIV   (TICK_DIV),
      .STABLE_CNT (STABLE_CNT)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .in_port (in_port),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   int               m_tick;
   bit               m_init;
   logic [WIDTH-1:0] m_s1, m_s2, m_stable, m_mask, m_cap;
   int               m_cnt [WIDTH];
   logic [1:0]       m_cfg;
   logic [31:0]      m_rd;
   logic             m_irq;

   // Prediction of the next stable level / recorded edges from the current state.
   logic [WIDTH-1:0] p_stable, p_edges;
   int               p_cnt [WIDTH];
   bit               p_init;
   int               p_tick;

   task automatic model_predict();
      logic [WIDTH-1:0] r, f;
      p_stable = m_stable;
      p_cnt    = m_cnt;
      p_init   = 1'b0;
      p_tick   = 0;
`ifdef SWITCH_EVENT_CTRL_DEBOUNCE_EN
      begin
         bit tk;
         tk     = (m_tick == TICK_DIV - 1);
         p_tick = tk ? 0 : m_tick + 1;
         p_init = m_init;
         if (m_init) begin
            if (tk) begin
               p_stable = m_s2;
               p_init   = 1'b0;
            end
         end else if (tk) begin
            for (int i = 0; i < WIDTH; i++) begin
               if (m_s2[i] != m_stable[i]) begin
                  if (m_cnt[i] + 1 >= STABLE_CNT) begin
                     p_stable[i] = m_s2[i];
                     p_cnt[i]    = 0;
                  end else begin
                     p_cnt[i] = m_cnt[i] + 1;
                  end
               end else begin
                  p_cnt[i] = 0;
               end
            end
         end
      end
`else
      p_stable = m_s2;
`endif
      r       = p_stable & ~m_stable;
      f       = ~p_stable & m_stable;
      p_edges = '0;
      if (!m_init) begin
         if (m_cfg[0]) p_edges = p_edges | r;
         if (m_cfg[1]) p_edges = p_edges | f;
      end
   endtask

   task automatic model_clock();
      logic [WIDTH-1:0] n_cap;
      if (reset) begin
         m_tick = 0; m_init = 1'b1;
         m_s1 = '0; m_s2 = '0; m_stable = '0; m_mask = '0; m_cap = '0;
         m_cfg = 2'b11; m_rd = '0; m_irq = 1'b0;
         foreach (m_cnt[i]) m_cnt[i] = 0;
      end else begin
         model_predict();
         n_cap = m_cap;
         if (bus.write && bus.address == 2'd2) n_cap = n_cap & ~bus.writedata[WIDTH-1:0];
         n_cap = n_cap | p_edges;
         if (bus.read) begin
            case (bus.address)
               2'd0:    m_rd = 32'(m_stable);
               2'd1:    m_rd = 32'(m_mask);
               2'd2:    m_rd = 32'(m_cap);
               default: m_rd = 32'(m_cfg);
            endcase
         end
         m_irq = |(m_cap & m_mask);
         if (bus.write && bus.address == 2'd1) m_mask = bus.writedata[WIDTH-1:0];
         if (bus.write && bus.address == 2'd3) m_cfg = bus.writedata[1:0];
         m_cap    = n_cap;
         m_stable = p_stable;
         m_cnt    = p_cnt;
         m_init   = p_init;
         m_tick   = p_tick;
         m_s2     = m_s1;
         m_s1     = in_port;
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      model_clock();
      #1;
      check("readdata", bus.readdata, m_rd);
      check("irq", 32'(irq), 32'(m_irq));
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) step();
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      bus.address = a; bus.writedata = d; bus.write = 1'b1;
      step();
      bus.write = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
      bus.address = a; bus.read = 1'b1;
      step();
      bus.read = 1'b0;
      d = bus.readdata;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      int          lat;
      bit          found;

      bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;

      // Reset with a level held through reset release.
      in_port = 18'h00005;
      reset   = 1'b1;
      wait_cycles(3);
      check("reset_readdata", bus.readdata, 32'h0);
      check("reset_irq", 32'(irq), 32'h0);
      reset = 1'b0;
      wait_cycles(TICK_DIV + 2);
      bus_rd(2'd0, d); check("init_stable", d, 32'h5);
      bus_rd(2'd2, d); check("init_edge", d, DEB ? 32'h0 : 32'h5);
      check("init_irq", 32'(irq), 32'h0);
      bus_rd(2'd3, d); check("cfg_reset", d, 32'h3);

      // Masked bit0 rise -> capture and irq, then W1C drops irq.
      in_port = 18'h00004;
      wait_cycles(SETTLE);
      bus_wr(2'd2, 32'hFFFF_FFFF);
      bus_wr(2'd1, 32'h1);
      in_port = 18'h00005;
      lat = 0;
      while (irq !== 1'b1 && lat < 40) begin
         step();
         lat++;
      end
`ifdef SWITCH_EVENT_CTRL_DEBOUNCE_EN
      check("irq_latency_in_window", 32'(lat >= 12 && lat <= 15), 32'h1);
`else
      check("irq_latency", 32'(lat), 32'd4);
`endif
      bus_rd(2'd2, d); check("edge_bit0", d, 32'h1);
      bus_rd(2'd0, d); check("stable_bit0", d, 32'h5);
      bus_wr(2'd2, 32'h1);
      step();
      check("irq_after_w1c", 32'(irq), 32'h0);

      // Short glitch on bit3 (two ticks).
      bus_wr(2'd2, 32'hFFFF_FFFF);
      in_port = 18'h0000D;
      wait_cycles(2 * TICK_DIV);
      in_port = 18'h00005;
      wait_cycles(SETTLE);
      bus_rd(2'd0, d); check("glitch_stable", d, 32'h5);
      bus_rd(2'd2, d); check("glitch_edge", d, DEB ? 32'h0 : 32'h8);

      // Edge selection: rise-only ignores a fall, fall-only captures it.
      in_port = 18'h00007;
      wait_cycles(SETTLE);
      bus_wr(2'd2, 32'hFFFF_FFFF);
      bus_wr(2'd3, 32'h1);
      in_port = 18'h00005;
      wait_cycles(SETTLE);
      bus_rd(2'd2, d); check("cfg01_fall_ignored", d, 32'h0);
      bus_wr(2'd3, 32'h2);
      in_port = 18'h00007;
      wait_cycles(SETTLE);
      bus_rd(2'd2, d); check("cfg10_rise_ignored", d, 32'h0);
      in_port = 18'h00005;
      wait_cycles(SETTLE);
      bus_rd(2'd2, d); check("cfg10_fall_captured", d, 32'h2);
      bus_rd(2'd3, d); check("cfg_readback", d, 32'h2);

      // Write to address 0 is ignored.
      bus_wr(2'd0, 32'h0003_FFFF);
      bus_rd(2'd0, d); check("addr0_write_ignored", d, 32'h5);

      // W1C of bit0 in the very cycle a new bit0 edge is recorded.
      bus_wr(2'd3, 32'h3);
      bus_wr(2'd2, 32'hFFFF_FFFF);
      in_port = 18'h00004;
      wait_cycles(SETTLE);
      bus_rd(2'd2, d); check("w1c_setup", d, 32'h1);
      in_port = 18'h00005;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         model_predict();
         if (p_edges[0]) found = 1'b1;
         else step();
      end
      check("w1c_edge_found", 32'(found), 32'h1);
      bus_wr(2'd2, 32'h1);
      bus_rd(2'd2, d); check("w1c_edge_wins", 32'(d[0]), 32'h1);

`ifndef SWITCH_EVENT_CTRL_DEBOUNCE_EN
      // Without the filter, a bit2 rise is captured 3 cycles after the change.
      in_port = 18'h00001;
      wait_cycles(6);
      bus_wr(2'd2, 32'hFFFF_FFFF);
      in_port = 18'h00005;
      step();
      step();
      bus.address = 2'd2; bus.read = 1'b1;
      step();
      check("nodeb_edge_not_yet", 32'(bus.readdata[2]), 32'h0);
      step();
      bus.read = 1'b0;
      check("nodeb_edge_at_3", 32'(bus.readdata[2]), 32'h1);
`endif

      // Randomized traffic with occasional mid-debounce resets.
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 23) == 0)
            in_port = in_port ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
         bus.read      = 1'($urandom_range(0, 1));
         bus.write     = ($urandom_range(0, 5) == 0);
         bus.address   = 2'($urandom_range(0, 3));
         bus.writedata = $urandom();
         reset         = ($urandom_range(0, 299) == 0);
         step();
      end
      reset = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
      wait_cycles(SETTLE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
